// File: rtl/spi_regbank_slave.sv
// rtl/spi_regbank_slave.sv - SPI register-bank slave, all CPOL/CPHA modes, optional status snapshot (SPI_REGBANK_SNAPSHOT_EN)
module spi_regbank_slave #(
    parameter int NUM_CFG     = 8,
    parameter int NUM_STATUS  = 8,
    parameter int REG_WIDTH   = 8,
    parameter int ADDR_WIDTH  = 7,
    parameter int SYNC_STAGES = 2,
    parameter logic [REG_WIDTH-1:0] CFG_RESET = '0
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [1:0]                       mode,
    input  logic                             spi_cs_n,
    input  logic                             spi_clk,
    input  logic                             spi_mosi,
    output logic                             spi_miso,
    output logic [NUM_CFG*REG_WIDTH-1:0]     config_regs,
    input  logic [NUM_STATUS*REG_WIDTH-1:0]  status_regs,
    output logic                             cfg_wr_stb,
    output logic [ADDR_WIDTH-1:0]            cfg_wr_addr
);

    localparam int SIW = (ADDR_WIDTH + 1 > REG_WIDTH) ? ADDR_WIDTH + 1 : REG_WIDTH;
    localparam int BCW = $clog2(SIW);
    localparam logic [BCW-1:0]        CMD_LAST  = BCW'(ADDR_WIDTH);
    localparam logic [BCW-1:0]        WORD_LAST = BCW'(REG_WIDTH - 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_MAX  = ADDR_WIDTH'(NUM_CFG + NUM_STATUS - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_CMD, ST_DATA} state_t;

    state_t state_q, state_d;

    logic [SYNC_STAGES-1:0]      cs_sync_q, sclk_sync_q, mosi_sync_q;
    logic [SYNC_STAGES-1:0][1:0] mode_sync_q;
    logic                        sclk_prev_q;

    logic                        cpol_q, cpha_q, rw_q, load_pend_q, skip_q, miso_q;
    logic [BCW-1:0]              bit_cnt_q;
    logic [SIW-2:0]              shift_in_q;
    logic [REG_WIDTH-1:0]        shift_out_q;
    logic [ADDR_WIDTH-1:0]       addr_q;
    logic [NUM_CFG*REG_WIDTH-1:0] cfg_q;
    logic                        stb_q;
    logic [ADDR_WIDTH-1:0]       wr_addr_q;

    logic                        cs_s, sclk_s, mosi_s;
    logic [1:0]                  mode_s;
    logic                        sclk_rise, sclk_fall, sample_edge, shift_edge;
    logic                        start, abort, cmd_done, word_done;
    logic [SIW-1:0]              nxt_bits;
    logic [ADDR_WIDTH-1:0]       addr_nxt;
    logic [REG_WIDTH-1:0]        rd_val;
    logic [NUM_STATUS*REG_WIDTH-1:0] sts_src;

    assign cs_s   = cs_sync_q[SYNC_STAGES-1];
    assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];
    assign mode_s = mode_sync_q[SYNC_STAGES-1];

    assign sclk_rise   = sclk_s & ~sclk_prev_q;
    assign sclk_fall   = ~sclk_s & sclk_prev_q;
    assign sample_edge = (cpol_q == cpha_q) ? sclk_rise : sclk_fall;
    assign shift_edge  = (cpol_q == cpha_q) ? sclk_fall : sclk_rise;

    assign nxt_bits = {shift_in_q, mosi_s};
    assign addr_nxt = (addr_q == ADDR_MAX) ? '0 : addr_q + 1'b1;

    assign spi_miso    = miso_q;
    assign config_regs = cfg_q;
    assign cfg_wr_stb  = stb_q;
    assign cfg_wr_addr = wr_addr_q;

`ifdef SPI_REGBANK_SNAPSHOT_EN
    logic [NUM_STATUS*REG_WIDTH-1:0] snap_q;

    // Freeze status inputs as the transaction opens so a burst read is coherent
    always_ff @(posedge clk) begin
        if (rst) begin
            snap_q <= '0;
        end else if (start) begin
            snap_q <= status_regs;
        end
    end

    assign sts_src = snap_q;
`else
    assign sts_src = status_regs;
`endif

    // Input synchronizers plus the extra SCLK flop used for edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            cs_sync_q   <= '1;
            sclk_sync_q <= '0;
            mosi_sync_q <= '0;
            mode_sync_q <= '0;
            sclk_prev_q <= 1'b0;
        end else begin
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n};
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi_clk};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
            mode_sync_q <= {mode_sync_q[SYNC_STAGES-2:0], mode};
            sclk_prev_q <= sclk_s;
        end
    end

    // Read mux over the unified address map; unmapped addresses read as zero
    always_comb begin
        rd_val = '0;
        for (int i = 0; i < NUM_CFG; i++) begin
            if (addr_q == ADDR_WIDTH'(i)) rd_val = cfg_q[i*REG_WIDTH +: REG_WIDTH];
        end
        for (int i = 0; i < NUM_STATUS; i++) begin
            if (addr_q == ADDR_WIDTH'(NUM_CFG + i)) rd_val = sts_src[i*REG_WIDTH +: REG_WIDTH];
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic; CS release takes priority over a coincident final edge
    always_comb begin
        state_d   = state_q;
        start     = 1'b0;
        abort     = 1'b0;
        cmd_done  = 1'b0;
        word_done = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!cs_s) begin
                    state_d = ST_CMD;
                    start   = 1'b1;
                end
            end
            ST_CMD: begin
                if (cs_s) begin
                    state_d = ST_IDLE;
                    abort   = 1'b1;
                end else if (sample_edge && bit_cnt_q == CMD_LAST) begin
                    state_d  = ST_DATA;
                    cmd_done = 1'b1;
                end
            end
            ST_DATA: begin
                if (cs_s) begin
                    state_d = ST_IDLE;
                    abort   = 1'b1;
                end else if (sample_edge && bit_cnt_q == WORD_LAST) begin
                    word_done = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath: command decode, shift registers, config writes and MISO drive
    always_ff @(posedge clk) begin
        if (rst) begin
            cpol_q      <= 1'b0;
            cpha_q      <= 1'b0;
            rw_q        <= 1'b0;
            load_pend_q <= 1'b0;
            skip_q      <= 1'b0;
            miso_q      <= 1'b0;
            bit_cnt_q   <= '0;
            shift_in_q  <= '0;
            shift_out_q <= '0;
            addr_q      <= '0;
            cfg_q       <= {NUM_CFG{CFG_RESET}};
            stb_q       <= 1'b0;
            wr_addr_q   <= '0;
        end else begin
            stb_q <= 1'b0;
            if (start) begin
                cpol_q      <= mode_s[1];
                cpha_q      <= mode_s[0];
                bit_cnt_q   <= '0;
                load_pend_q <= 1'b0;
                skip_q      <= 1'b0;
                miso_q      <= 1'b0;
            end else if (abort || state_q == ST_IDLE) begin
                miso_q      <= 1'b0;
                load_pend_q <= 1'b0;
                skip_q      <= 1'b0;
                bit_cnt_q   <= '0;
            end else if (state_q == ST_CMD) begin
                if (sample_edge) begin
                    shift_in_q <= nxt_bits[SIW-2:0];
                    bit_cnt_q  <= bit_cnt_q + 1'b1;
                    if (cmd_done) begin
                        rw_q        <= nxt_bits[ADDR_WIDTH];
                        addr_q      <= nxt_bits[ADDR_WIDTH-1:0];
                        bit_cnt_q   <= '0;
                        load_pend_q <= ~nxt_bits[ADDR_WIDTH];
                    end
                end
            end else if (load_pend_q) begin
                // CPHA=0 presents the MSB now, so the trailing edge that follows
                // the word boundary must not shift
                load_pend_q <= 1'b0;
                if (!cpha_q) begin
                    miso_q      <= rd_val[REG_WIDTH-1];
                    shift_out_q <= rd_val << 1;
                    skip_q      <= 1'b1;
                end else begin
                    shift_out_q <= rd_val;
                end
            end else if (sample_edge) begin
                shift_in_q <= nxt_bits[SIW-2:0];
                bit_cnt_q  <= bit_cnt_q + 1'b1;
                if (word_done) begin
                    bit_cnt_q <= '0;
                    addr_q    <= addr_nxt;
                    if (rw_q) begin
                        for (int i = 0; i < NUM_CFG; i++) begin
                            if (addr_q == ADDR_WIDTH'(i)) begin
                                cfg_q[i*REG_WIDTH +: REG_WIDTH] <= nxt_bits[REG_WIDTH-1:0];
                                stb_q     <= 1'b1;
                                wr_addr_q <= addr_q;
                            end
                        end
                    end else begin
                        load_pend_q <= 1'b1;
                    end
                end
            end else if (shift_edge && !rw_q) begin
                if (skip_q) begin
                    skip_q <= 1'b0;
                end else begin
                    miso_q      <= shift_out_q[REG_WIDTH-1];
                    shift_out_q <= shift_out_q << 1;
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_regbank_slave.sv
// tb/tb_spi_regbank_slave.sv - directed self-checking bench for spi_regbank_slave
module tb_spi_regbank_slave;

    localparam int HALF = 8;

`ifdef SPI_REGBANK_SNAPSHOT_EN
    localparam logic [7:0] SNAP_EXP = 8'h10;
`else
    localparam logic [7:0] SNAP_EXP = 8'h99;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  mode;
    logic        spi_cs_n, spi_clk, spi_mosi;
    logic        spi_miso;
    logic [63:0] config_regs;
    logic [63:0] status_regs;
    logic        cfg_wr_stb;
    logic [6:0]  cfg_wr_addr;

    int          n_cmp  = 0;
    int          n_fail = 0;
    int          stb_cycles = 0;
    logic [1:0]  cur_mode;

    spi_regbank_slave dut (
        .clk         (clk),
        .rst         (rst),
        .mode        (mode),
        .spi_cs_n    (spi_cs_n),
        .spi_clk     (spi_clk),
        .spi_mosi    (spi_mosi),
        .spi_miso    (spi_miso),
        .config_regs (config_regs),
        .status_regs (status_regs),
        .cfg_wr_stb  (cfg_wr_stb),
        .cfg_wr_addr (cfg_wr_addr)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (cfg_wr_stb === 1'b1) stb_cycles++;
    end

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic spi_begin(input logic [1:0] m);
        cur_mode = m;
        mode     = m;
        spi_clk  = m[1];
        spi_cs_n = 1'b1;
        wait_clks(10);
        spi_cs_n = 1'b0;
        wait_clks(HALF);
    endtask

    task automatic spi_end();
        wait_clks(HALF);
        spi_cs_n = 1'b1;
        wait_clks(HALF);
    endtask

    task automatic spi_word(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 7; i > 7 - nbits; i--) begin
            if (!cur_mode[0]) begin
                spi_mosi = tx[i];
                wait_clks(HALF);
                spi_clk = ~cur_mode[1];
                rx[i]   = spi_miso;
                wait_clks(HALF);
                spi_clk = cur_mode[1];
            end else begin
                spi_clk  = ~cur_mode[1];
                spi_mosi = tx[i];
                wait_clks(HALF);
                spi_clk = cur_mode[1];
                rx[i]   = spi_miso;
                wait_clks(HALF);
            end
        end
    endtask

    task automatic test_reset();
        n_cmp++; if (config_regs !== 64'h0) begin n_fail++; $display("FAIL reset_cfg: got %h want %h", config_regs, 64'h0); end
        n_cmp++; if (spi_miso !== 1'b0) begin n_fail++; $display("FAIL reset_miso: got %b want 0", spi_miso); end
        n_cmp++; if (cfg_wr_stb !== 1'b0) begin n_fail++; $display("FAIL reset_stb: got %b want 0", cfg_wr_stb); end
        n_cmp++; if (cfg_wr_addr !== 7'h0) begin n_fail++; $display("FAIL reset_wr_addr: got %h want 0", cfg_wr_addr); end
    endtask

    task automatic test_write_mode0();
        logic [7:0] rx_cmd, rx_dat;
        int s0;
        s0 = stb_cycles;
        spi_begin(2'd0);
        spi_word(8'h82, 8, rx_cmd);
        spi_word(8'hA5, 8, rx_dat);
        spi_end();
        n_cmp++; if (config_regs !== 64'h0000_0000_00A5_0000) begin n_fail++; $display("FAIL write_cfg: got %h want %h", config_regs, 64'h0000_0000_00A5_0000); end
        n_cmp++; if (stb_cycles - s0 !== 1) begin n_fail++; $display("FAIL write_stb_cycles: got %0d want 1", stb_cycles - s0); end
        n_cmp++; if (cfg_wr_addr !== 7'd2) begin n_fail++; $display("FAIL write_wr_addr: got %0d want 2", cfg_wr_addr); end
        n_cmp++; if (rx_cmd !== 8'h00) begin n_fail++; $display("FAIL write_miso_cmd: got %h want 00", rx_cmd); end
        n_cmp++; if (rx_dat !== 8'h00) begin n_fail++; $display("FAIL write_miso_data: got %h want 00", rx_dat); end
    endtask

    task automatic test_read_modes();
        logic [7:0] rx_cmd, rx0, rx1;
        for (int m = 0; m < 3; m++) begin
            spi_begin(2'(m));
            spi_word(8'h0C, 8, rx_cmd);
            spi_word(8'h00, 8, rx0);
            spi_end();
            n_cmp++; if (rx_cmd !== 8'h00) begin n_fail++; $display("FAIL read_m%0d_cmd_miso: got %h want 00", m, rx_cmd); end
            n_cmp++; if (rx0 !== 8'hC4) begin n_fail++; $display("FAIL read_m%0d_data: got %h want C4", m, rx0); end
        end
        spi_begin(2'd3);
        spi_word(8'h0C, 8, rx_cmd);
        spi_word(8'h00, 8, rx0);
        spi_word(8'h00, 8, rx1);
        spi_end();
        n_cmp++; if (rx_cmd !== 8'h00) begin n_fail++; $display("FAIL read_m3_cmd_miso: got %h want 00", rx_cmd); end
        n_cmp++; if (rx0 !== 8'hC4) begin n_fail++; $display("FAIL read_m3_data0: got %h want C4", rx0); end
        n_cmp++; if (rx1 !== 8'h3B) begin n_fail++; $display("FAIL read_m3_data1: got %h want 3B", rx1); end
        n_cmp++; if (spi_miso !== 1'b0) begin n_fail++; $display("FAIL read_idle_miso: got %b want 0", spi_miso); end
    endtask

    task automatic test_burst();
        logic [7:0] rx;
        logic [7:0] r0, r1, r2;
        int s0;
        s0 = stb_cycles;
        spi_begin(2'd0);
        spi_word(8'h86, 8, rx);
        spi_word(8'h11, 8, rx);
        spi_word(8'h22, 8, rx);
        spi_word(8'h33, 8, rx);
        spi_end();
        n_cmp++; if (config_regs !== 64'h2211_0000_00A5_0000) begin n_fail++; $display("FAIL burst_cfg: got %h want %h", config_regs, 64'h2211_0000_00A5_0000); end
        n_cmp++; if (stb_cycles - s0 !== 2) begin n_fail++; $display("FAIL burst_stb_cycles: got %0d want 2", stb_cycles - s0); end
        n_cmp++; if (cfg_wr_addr !== 7'd7) begin n_fail++; $display("FAIL burst_wr_addr: got %0d want 7", cfg_wr_addr); end
        spi_begin(2'd0);
        spi_word(8'h80, 8, rx);
        spi_word(8'h5C, 8, rx);
        spi_end();
        spi_begin(2'd0);
        spi_word(8'h0F, 8, rx);
        spi_word(8'h00, 8, r0);
        spi_word(8'h00, 8, r1);
        spi_word(8'h00, 8, r2);
        spi_end();
        n_cmp++; if (r0 !== 8'h7E) begin n_fail++; $display("FAIL wrap_status7: got %h want 7E", r0); end
        n_cmp++; if (r1 !== 8'h5C) begin n_fail++; $display("FAIL wrap_cfg0: got %h want 5C", r1); end
        n_cmp++; if (r2 !== 8'h00) begin n_fail++; $display("FAIL wrap_cfg1: got %h want 00", r2); end
    endtask

    task automatic test_abort();
        logic [7:0] rx;
        int s0;
        s0 = stb_cycles;
        spi_begin(2'd0);
        spi_word(8'h83, 8, rx);
        spi_word(8'hFF, 5, rx);
        spi_end();
        n_cmp++; if (stb_cycles - s0 !== 0) begin n_fail++; $display("FAIL abort_stb: got %0d want 0", stb_cycles - s0); end
        n_cmp++; if (config_regs[31:24] !== 8'h00) begin n_fail++; $display("FAIL abort_cfg3: got %h want 00", config_regs[31:24]); end
        s0 = stb_cycles;
        spi_begin(2'd3);
        spi_word(8'h83, 8, rx);
        spi_word(8'h3C, 8, rx);
        spi_end();
        n_cmp++; if (config_regs[31:24] !== 8'h3C) begin n_fail++; $display("FAIL abort_next_cfg3: got %h want 3C", config_regs[31:24]); end
        n_cmp++; if (stb_cycles - s0 !== 1) begin n_fail++; $display("FAIL abort_next_stb: got %0d want 1", stb_cycles - s0); end
        n_cmp++; if (cfg_wr_addr !== 7'd3) begin n_fail++; $display("FAIL abort_next_wr_addr: got %0d want 3", cfg_wr_addr); end
        spi_begin(2'd1);
        spi_word(8'h03, 8, rx);
        spi_word(8'h00, 8, rx);
        spi_end();
        n_cmp++; if (rx !== 8'h3C) begin n_fail++; $display("FAIL abort_readback: got %h want 3C", rx); end
    endtask

    task automatic test_reset_mid_burst();
        logic [7:0] rx;
        int s0;
        spi_begin(2'd2);
        spi_word(8'h80, 8, rx);
        spi_word(8'hAA, 8, rx);
        spi_word(8'hBB, 8, rx);
        spi_end();
        spi_begin(2'd2);
        spi_word(8'h00, 8, rx);
        spi_word(8'h00, 8, rx);
        n_cmp++; if (rx !== 8'hAA) begin n_fail++; $display("FAIL midrst_read0: got %h want AA", rx); end
        spi_word(8'h00, 3, rx);
        wait_clks(4);
        n_cmp++; if (spi_miso !== 1'b1) begin n_fail++; $display("FAIL midrst_pre_miso: got %b want 1", spi_miso); end
        rst = 1'b1;
        wait_clks(2);
        n_cmp++; if (config_regs !== 64'h0) begin n_fail++; $display("FAIL midrst_cfg: got %h want 0", config_regs); end
        n_cmp++; if (spi_miso !== 1'b0) begin n_fail++; $display("FAIL midrst_miso: got %b want 0", spi_miso); end
        spi_cs_n = 1'b1;
        wait_clks(4);
        rst = 1'b0;
        wait_clks(4);
        s0 = stb_cycles;
        spi_begin(2'd0);
        spi_word(8'h81, 8, rx);
        spi_word(8'h42, 8, rx);
        spi_end();
        n_cmp++; if (config_regs !== 64'h0000_0000_0000_4200) begin n_fail++; $display("FAIL midrst_next_cfg: got %h want %h", config_regs, 64'h0000_0000_0000_4200); end
        n_cmp++; if (stb_cycles - s0 !== 1) begin n_fail++; $display("FAIL midrst_next_stb: got %0d want 1", stb_cycles - s0); end
        spi_begin(2'd0);
        spi_word(8'h01, 8, rx);
        spi_word(8'h00, 8, rx);
        spi_end();
        n_cmp++; if (rx !== 8'h42) begin n_fail++; $display("FAIL midrst_readback: got %h want 42", rx); end
    endtask

    task automatic test_snapshot();
        logic [7:0] rx, r0, r1;
        status_regs[47:40] = 8'h10;
        spi_begin(2'd0);
        spi_word(8'h0C, 8, rx);
        status_regs[47:40] = 8'h99;
        spi_word(8'h00, 8, r0);
        spi_word(8'h00, 8, r1);
        spi_end();
        n_cmp++; if (r0 !== 8'hC4) begin n_fail++; $display("FAIL snap_word0: got %h want C4", r0); end
        n_cmp++; if (r1 !== SNAP_EXP) begin n_fail++; $display("FAIL snap_word1: got %h want %h", r1, SNAP_EXP); end
    endtask

    initial begin
        rst         = 1'b1;
        mode        = 2'd0;
        cur_mode    = 2'd0;
        spi_cs_n    = 1'b1;
        spi_clk     = 1'b0;
        spi_mosi    = 1'b0;
        status_regs = 64'h7E00_3BC4_0000_0000;
        wait_clks(5);
        test_reset();
        rst = 1'b0;
        wait_clks(5);
        test_reset();
        test_write_mode0();
        test_read_modes();
        test_burst();
        test_abort();
        test_reset_mid_burst();
        test_snapshot();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
